// File: rtl/mfb_frame_len_check_if.sv
// rtl/mfb_frame_len_check_if.sv - single-region MFB stream bundle with frame length side-band
//
// Ports (modport view):
//   master : drives data, sof_pos, eof_pos, sof, eof, error, len_under, len_over,
//            frame_len, src_rdy; samples dst_rdy
//   slave  : samples everything the master drives; drives dst_rdy
// The length side-band (len_under, len_over, frame_len) is only meaningful on the
// output side of mfb_frame_len_check; upstream producers leave it unused.
interface mfb_frame_len_check_if #(
    parameter int REGION_SIZE = 8,
    parameter int BLOCK_SIZE  = 8,
    parameter int ITEM_WIDTH  = 8,
    parameter int LEN_WIDTH   = 16
);
    localparam int DATA_W = REGION_SIZE * BLOCK_SIZE * ITEM_WIDTH;
    localparam int SP_W   = (REGION_SIZE > 1) ? $clog2(REGION_SIZE) : 1;
    localparam int EP_W   = $clog2(REGION_SIZE * BLOCK_SIZE);

    logic [DATA_W-1:0]    data;
    logic [SP_W-1:0]      sof_pos;
    logic [EP_W-1:0]      eof_pos;
    logic                 sof;
    logic                 eof;
    logic                 error;
    logic                 len_under;
    logic                 len_over;
    logic [LEN_WIDTH-1:0] frame_len;
    logic                 src_rdy;
    logic                 dst_rdy;

    modport master (
        output data, sof_pos, eof_pos, sof, eof, error,
        output len_under, len_over, frame_len, src_rdy,
        input  dst_rdy
    );

    modport slave (
        input  data, sof_pos, eof_pos, sof, eof, error,
        input  len_under, len_over, frame_len, src_rdy,
        output dst_rdy
    );
endinterface

// File: rtl/mfb_frame_len_check.sv
// rtl/mfb_frame_len_check.sv - measures MFB frame byte length and flags undersize/oversize frames
//
// Ports:
//   CLK   : clock
//   RESET : synchronous active-high reset
//   rx    : slave side, words from the UMII decoder (side-band length fields unused)
//   tx    : master side, registered copy of rx plus frame_len/len_under/len_over,
//           error = rx error OR length error; length fields are non-zero only with eof
module mfb_frame_len_check #(
    parameter int REGIONS     = 1,
    parameter int REGION_SIZE = 8,
    parameter int BLOCK_SIZE  = 8,
    parameter int ITEM_WIDTH  = 8,
    parameter int MIN_LEN     = 64,
    parameter int MAX_LEN     = 1526,
    parameter int LEN_WIDTH   = 16
) (
    input  logic                    CLK,
    input  logic                    RESET,
    mfb_frame_len_check_if.slave    rx,
    mfb_frame_len_check_if.master   tx
);
    localparam int WORD_BYTES = REGION_SIZE * BLOCK_SIZE;
    localparam int DATA_W     = REGIONS * WORD_BYTES * ITEM_WIDTH;
    localparam int SP_W       = (REGION_SIZE > 1) ? $clog2(REGION_SIZE) : 1;
    localparam int EP_W       = $clog2(WORD_BYTES);

    localparam logic [LEN_WIDTH-1:0] W_LEN   = LEN_WIDTH'(WORD_BYTES);
    localparam logic [LEN_WIDTH-1:0] BLK_LEN = LEN_WIDTH'(BLOCK_SIZE);
    localparam logic [LEN_WIDTH-1:0] MIN_L   = LEN_WIDTH'(MIN_LEN);
    localparam logic [LEN_WIDTH-1:0] MAX_L   = LEN_WIDTH'(MAX_LEN);
    localparam logic [LEN_WIDTH-1:0] ONE     = LEN_WIDTH'(1);

    function automatic logic [LEN_WIDTH-1:0] sat_add(
        input logic [LEN_WIDTH-1:0] a,
        input logic [LEN_WIDTH-1:0] b
    );
        logic [LEN_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[LEN_WIDTH] ? '1 : s[LEN_WIDTH-1:0];
    endfunction

    // Output register
    logic [DATA_W-1:0]    data_q;
    logic [SP_W-1:0]      sof_pos_q;
    logic [EP_W-1:0]      eof_pos_q;
    logic                 sof_q;
    logic                 eof_q;
    logic                 err_q;
    logic                 under_q;
    logic                 over_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic                 src_rdy_q;

    // Frame tracking state
    logic                 frame_active;
    logic [LEN_WIDTH-1:0] cnt;

    logic                 accept;
    logic [LEN_WIDTH-1:0] s_byte;
    logic [LEN_WIDTH-1:0] e_plus1;
    logic [LEN_WIDTH-1:0] base;
    logic [LEN_WIDTH-1:0] len;
    logic [LEN_WIDTH-1:0] cnt_nxt;
    logic                 active_nxt;
    logic                 single;
    logic                 under;
    logic                 over;

    // The output slot frees up when it is empty or being drained this cycle.
    assign rx.dst_rdy = tx.dst_rdy | ~src_rdy_q;
    assign accept     = rx.src_rdy & rx.dst_rdy;

    always_comb begin
        s_byte     = LEN_WIDTH'(rx.sof_pos) * BLK_LEN;
        e_plus1    = LEN_WIDTH'(rx.eof_pos) + ONE;
        // An EOF with no frame open (orphan) measures from byte 0 of this word.
        base       = frame_active ? cnt : '0;
        // S <= E means the SOF and EOF belong to the same frame inside this word.
        single     = rx.sof & rx.eof & (s_byte < e_plus1);
        len        = single ? (e_plus1 - s_byte) : sat_add(base, e_plus1);
        under      = (len < MIN_L);
        // All-ones is the saturation value, so it is always treated as oversize.
        over       = (len > MAX_L) | (len == '1);
        cnt_nxt    = cnt;
        active_nxt = frame_active;
        if (rx.sof && !single) begin
            // New frame opens here; any previously open frame without EOF is dropped.
            cnt_nxt    = W_LEN - s_byte;
            active_nxt = 1'b1;
        end else if (rx.eof) begin
            active_nxt = 1'b0;
        end else if (frame_active) begin
            cnt_nxt = sat_add(cnt, W_LEN);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            data_q       <= '0;
            sof_pos_q    <= '0;
            eof_pos_q    <= '0;
            sof_q        <= 1'b0;
            eof_q        <= 1'b0;
            err_q        <= 1'b0;
            under_q      <= 1'b0;
            over_q       <= 1'b0;
            len_q        <= '0;
            src_rdy_q    <= 1'b0;
            frame_active <= 1'b0;
            cnt          <= '0;
        end else if (accept) begin
            data_q       <= rx.data;
            sof_pos_q    <= rx.sof_pos;
            eof_pos_q    <= rx.eof_pos;
            sof_q        <= rx.sof;
            eof_q        <= rx.eof;
            err_q        <= rx.eof & (rx.error | under | over);
            under_q      <= rx.eof & under;
            over_q       <= rx.eof & over;
            len_q        <= rx.eof ? len : '0;
            src_rdy_q    <= 1'b1;
            frame_active <= active_nxt;
            cnt          <= cnt_nxt;
        end else if (tx.dst_rdy) begin
            src_rdy_q    <= 1'b0;
        end
    end

    assign tx.data      = data_q;
    assign tx.sof_pos   = sof_pos_q;
    assign tx.eof_pos   = eof_pos_q;
    assign tx.sof       = sof_q;
    assign tx.eof       = eof_q;
    assign tx.error     = err_q;
    assign tx.len_under = under_q;
    assign tx.len_over  = over_q;
    assign tx.frame_len = len_q;
    assign tx.src_rdy   = src_rdy_q;
endmodule

// File: tb/tb_mfb_frame_len_check.sv
// tb/tb_mfb_frame_len_check.sv - scoreboard bench for mfb_frame_len_check
module tb_mfb_frame_len_check;
    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1526;

    typedef struct packed {
        logic [511:0] data;
        logic [2:0]   sof_pos;
        logic [5:0]   eof_pos;
        logic         sof;
        logic         eof;
        logic         err;
        logic         under;
        logic         over;
        logic [15:0]  len;
    } tr_t;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    mfb_frame_len_check_if rx_if ();
    mfb_frame_len_check_if tx_if ();

    mfb_frame_len_check #(
        .REGIONS(1), .REGION_SIZE(8), .BLOCK_SIZE(8), .ITEM_WIDTH(8),
        .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .LEN_WIDTH(16)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .rx    (rx_if),
        .tx    (tx_if)
    );

    tr_t exp_q[$];
    int  n_cmp   = 0;
    int  n_bad   = 0;
    bit  bp_en   = 0;
    bit  idle_en = 0;

    function automatic void chk(input bit ok, input string name,
                                input logic [511:0] act, input logic [511:0] expv);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endfunction

    function automatic logic [511:0] rnd_data();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // Expected output word from the frame-level rules: length flags only on EOF.
    function automatic tr_t mk(input bit sof, input bit eof, input int sp, input int ep,
                               input bit rerr, input int len);
        tr_t t;
        t.data    = rnd_data();
        t.sof     = sof;
        t.eof     = eof;
        t.sof_pos = 3'(sp);
        t.eof_pos = 6'(ep);
        t.under   = eof && (len < MIN_LEN);
        t.over    = eof && (len > MAX_LEN);
        t.err     = eof && (rerr || t.under || t.over);
        t.len     = eof ? 16'(len) : 16'd0;
        return t;
    endfunction

    function automatic tr_t sample();
        tr_t c;
        c.data    = tx_if.data;
        c.sof_pos = tx_if.sof_pos;
        c.eof_pos = tx_if.eof_pos;
        c.sof     = tx_if.sof;
        c.eof     = tx_if.eof;
        c.err     = tx_if.error;
        c.under   = tx_if.len_under;
        c.over    = tx_if.len_over;
        c.len     = tx_if.frame_len;
        return c;
    endfunction

    // Downstream ready, changed just after each rising edge.
    always @(posedge CLK) begin
        #1;
        tx_if.dst_rdy = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor / scoreboard
    tr_t held;
    bit  held_v = 0;
    always @(negedge CLK) begin
        tr_t c;
        tr_t e;
        if (RESET) begin
            held_v = 0;
        end else begin
            c = sample();
            chk(rx_if.dst_rdy === (tx_if.dst_rdy | ~tx_if.src_rdy), "dst_rdy_comb",
                512'(rx_if.dst_rdy), 512'(tx_if.dst_rdy | ~tx_if.src_rdy));
            if (held_v) begin
                chk(tx_if.src_rdy === 1'b1, "hold_valid", 512'(tx_if.src_rdy), 512'(1));
                chk(c == held, "hold_stable", 512'(c[30:0]), 512'(held[30:0]));
            end
            if (tx_if.src_rdy && tx_if.dst_rdy) begin
                held_v = 0;
                if (exp_q.size() == 0) begin
                    chk(0, "unexpected_word", 512'(c.len), 512'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk(c.data == e.data, "data", c.data, e.data);
                    chk({c.sof, c.eof, c.sof_pos, c.eof_pos} == {e.sof, e.eof, e.sof_pos, e.eof_pos},
                        "sof_eof_pos", 512'({c.sof, c.eof, c.sof_pos, c.eof_pos}),
                        512'({e.sof, e.eof, e.sof_pos, e.eof_pos}));
                    chk({c.err, c.under, c.over} == {e.err, e.under, e.over}, "flags",
                        512'({c.err, c.under, c.over}), 512'({e.err, e.under, e.over}));
                    chk(c.len == e.len, "frame_len", 512'(c.len), 512'(e.len));
                end
            end else if (tx_if.src_rdy) begin
                held   = c;
                held_v = 1;
            end else begin
                held_v = 0;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the word was accepted.
    task automatic send(input tr_t w, input bit rerr);
        int guard;
        if (idle_en && $urandom_range(0, 3) == 0) begin
            rx_if.src_rdy = 1'b0;
            rx_if.data    = rnd_data();
            rx_if.sof     = 1'($urandom);
            rx_if.eof     = 1'($urandom);
            rx_if.sof_pos = 3'($urandom);
            rx_if.eof_pos = 6'($urandom);
            rx_if.error   = 1'($urandom);
            @(posedge CLK);
            #1;
        end
        rx_if.data    = w.data;
        rx_if.sof     = w.sof;
        rx_if.eof     = w.eof;
        rx_if.sof_pos = w.sof_pos;
        rx_if.eof_pos = w.eof_pos;
        rx_if.error   = rerr;
        rx_if.src_rdy = 1'b1;
        guard = 0;
        forever begin
            @(negedge CLK);
            if (rx_if.dst_rdy) begin
                exp_q.push_back(w);
                break;
            end
            guard++;
            if (guard > 1000) begin
                chk(0, "accept_timeout", 512'(guard), 512'(1000));
                break;
            end
            @(posedge CLK);
        end
        @(posedge CLK);
        #1;
        rx_if.src_rdy = 1'b0;
    endtask

    task automatic sendw(input bit sof, input bit eof, input int sp, input int ep,
                         input bit rerr, input int len);
        send(mk(sof, eof, sp, ep, rerr, len), rerr);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        bp_en = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            @(posedge CLK);
            guard++;
        end
        chk(exp_q.size() == 0, "drain", 512'(exp_q.size()), 512'(0));
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk(tx_if.src_rdy === 1'b0, {tag, "_src_rdy"}, 512'(tx_if.src_rdy), 512'(0));
        chk(tx_if.frame_len === 16'd0, {tag, "_frame_len"}, 512'(tx_if.frame_len), 512'(0));
        chk({tx_if.error, tx_if.len_under, tx_if.len_over} === 3'b000, {tag, "_flags"},
            512'({tx_if.error, tx_if.len_under, tx_if.len_over}), 512'(0));
    endtask

    task automatic random_frames(input int n);
        int st[$];
        int ln[$];
        bit fe[$];
        int q, prev_end, we, last_word, fi;
        for (int k = 0; k < n; k++) begin
            int L;
            L = $urandom_range(40, 1600);
            if (k == 0) begin
                q = 8 * $urandom_range(0, 7);
            end else begin
                prev_end = st[k-1] + ln[k-1] - 1;
                q  = ((prev_end + 8) / 8) * 8 + 8 * $urandom_range(0, 10);
                we = prev_end / 64;
                // A word carries at most one SOF and one EOF.
                if (q / 64 == we && (st[k-1] / 64 == we || (q + L - 1) / 64 == q / 64))
                    q = (we + 1) * 64;
            end
            st.push_back(q);
            ln.push_back(L);
            fe.push_back(($urandom_range(0, 9) == 0));
        end
        last_word = (st[n-1] + ln[n-1] - 1) / 64;
        fi = 0;
        for (int w = 0; w <= last_word; w++) begin
            int lo, hi, sp, ep, len;
            bit sof, eof, rerr;
            lo = 64 * w; hi = lo + 63;
            sof = 0; eof = 0; sp = 0; ep = $urandom_range(0, 63); len = 0;
            rerr = 1'($urandom);
            for (int j = fi; j < n && st[j] <= hi; j++) begin
                int e;
                if (st[j] >= lo) begin
                    sof = 1;
                    sp  = (st[j] - lo) / 8;
                end
                e = st[j] + ln[j] - 1;
                if (e >= lo && e <= hi) begin
                    eof  = 1;
                    ep   = e - lo;
                    len  = ln[j];
                    rerr = fe[j];
                end
            end
            if (!sof) sp = $urandom_range(0, 7);
            while (fi < n && st[fi] + ln[fi] - 1 <= hi) fi++;
            sendw(sof, eof, sp, ep, rerr, len);
        end
    endtask

    initial begin
        rx_if.src_rdy   = 1'b0;
        rx_if.data      = '0;
        rx_if.sof       = 1'b0;
        rx_if.eof       = 1'b0;
        rx_if.sof_pos   = '0;
        rx_if.eof_pos   = '0;
        rx_if.error     = 1'b0;
        rx_if.len_under = 1'b0;
        rx_if.len_over  = 1'b0;
        rx_if.frame_len = '0;
        tx_if.dst_rdy   = 1'b1;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_reset_state("reset");
        @(posedge CLK);
        #1;
        RESET = 1'b0;

        // 64 B frame in one word, with 1-cycle latency check
        sendw(1, 1, 0, 63, 0, 64);
        @(negedge CLK);
        chk(tx_if.src_rdy === 1'b1, "latency", 512'(tx_if.src_rdy), 512'(1));
        @(posedge CLK);
        #1;
        // 60 B runt
        sendw(1, 0, 1, 0, 0, 0);
        sendw(0, 1, 0, 3, 0, 60);
        // 1527 B and 1526 B over 24 words
        sendw(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 22; i++) sendw(0, 0, 0, 0, 1, 0);
        sendw(0, 1, 0, 54, 0, 1527);
        sendw(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 22; i++) sendw(0, 0, 0, 0, 0, 0);
        sendw(0, 1, 0, 53, 0, 1526);
        // EOF of an 80 B frame and SOF of the next in one word
        sendw(1, 0, 0, 0, 0, 0);
        sendw(1, 1, 4, 15, 0, 80);
        sendw(0, 1, 0, 31, 0, 64);
        // SOF while a frame is open abandons it; decoder error passes through
        sendw(1, 0, 0, 0, 0, 0);
        sendw(0, 0, 0, 0, 0, 0);
        sendw(1, 0, 2, 0, 0, 0);
        sendw(0, 1, 0, 9, 0, 58);
        sendw(1, 1, 0, 63, 1, 64);
        // Saturating length
        sendw(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 1100; i++) sendw(0, 0, 0, 0, 0, 0);
        sendw(0, 1, 0, 63, 0, 65535);
        drain();

        // Random frames under 50 % backpressure with idle input cycles
        bp_en   = 1;
        idle_en = 1;
        random_frames(1000);
        idle_en = 0;
        drain();

        // Reset mid-frame, then a fresh 100 B frame and an orphan EOF
        sendw(1, 0, 0, 0, 0, 0);
        sendw(0, 0, 0, 0, 0, 0);
        sendw(0, 0, 0, 0, 0, 0);
        drain();
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check_reset_state("mid_reset");
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        exp_q.delete();
        sendw(1, 0, 0, 0, 0, 0);
        sendw(0, 1, 0, 35, 0, 100);
        sendw(0, 1, 0, 9, 0, 10);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
